pc_fetch_unit: RTL and testbench

Parametrised successor to the single-register program counter. Holds the fetch PC and selects the next PC from reset, exception, resolved redirect, stall hold, return-address-stack (RAS) prediction or sequential increment. Sits at the head of the fetch stage and drives the instruction memory address. Receives redirect and exception requests from later pipeline stages.

---
 rtl/pc_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: reset / exception / redirect / stall / RAS / sequential next-PC selection.
// Optional return-address stack enabled by defining PC_FETCH_RAS_EN.
module pc_fetch_unit #(
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] EXC_VEC     = 32'h8000_0180,
   parameter int unsigned       INSTR_BYTES = 4,
   parameter int unsigned       RAS_DEPTH   = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              NotStall,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] RedirectAddr,
   input  logic              Exception,
   input  logic              Call,
   input  logic              Return,
   output logic [ADDR_W-1:0] PCResult,
   output logic [ADDR_W-1:0] PCPlus4,
   output logic [ADDR_W-1:0] EPC,
   output logic              PredTaken,
   output logic              RasEmpty,
   output logic              RasFull
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic              pred_q, pred_d;
   logic [ADDR_W-1:0] pc_plus_s;

   assign pc_plus_s = pc_q + STEP;

`ifdef PC_FETCH_RAS_EN
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   // top_q is the next free slot; the top entry lives at top_q-1 and the pointer wraps naturally
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [PTR_W-1:0]  top_q, top_d, top_m1_s, ras_widx_s;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ras_we_s;
   logic              ras_hit_s;

   assign top_m1_s  = top_q - PTR_W'(1);
   assign ras_hit_s = (cnt_q != CNT_W'(0));
`else
   logic unused_s;
   assign unused_s = ^{Call, Return, 32'(RAS_DEPTH)};
`endif

   // Next-PC selection and RAS control
   always_comb begin
      pc_d   = pc_q;
      epc_d  = epc_q;
      pred_d = pred_q;
`ifdef PC_FETCH_RAS_EN
      top_d      = top_q;
      cnt_d      = cnt_q;
      ras_we_s   = 1'b0;
      ras_widx_s = top_q;
`endif
      if (Exception) begin
         pc_d   = EXC_VEC;
         epc_d  = pc_q;
         pred_d = 1'b0;
`ifdef PC_FETCH_RAS_EN
         cnt_d  = CNT_W'(0);
`endif
      end else if (Redirect) begin
         pc_d   = RedirectAddr & ALIGN_MASK;
         pred_d = 1'b0;
      end else if (!NotStall) begin
         pc_d = pc_q;
      end else begin
`ifdef PC_FETCH_RAS_EN
         if (Return && ras_hit_s) begin
            pc_d   = ras_q[top_m1_s];
            pred_d = 1'b1;
            // Call+Return swaps the top entry in place
            if (Call) begin
               ras_we_s   = 1'b1;
               ras_widx_s = top_m1_s;
            end else begin
               top_d = top_m1_s;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end else begin
            pc_d   = pc_plus_s;
            pred_d = 1'b0;
            if (Call) begin
               ras_we_s   = 1'b1;
               ras_widx_s = top_q;
               top_d      = top_q + PTR_W'(1);
               cnt_d      = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
               ras_we_s = 1'b0;
            end
         end
`else
         pc_d   = pc_plus_s;
         pred_d = 1'b0;
`endif
      end
   end

   // PC, EPC and prediction flag registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q   <= RESET_VEC;
         epc_q  <= {ADDR_W{1'b0}};
         pred_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         epc_q  <= epc_d;
         pred_q <= pred_d;
      end
   end

`ifdef PC_FETCH_RAS_EN
   // RAS pointer, occupancy and storage
   always_ff @(posedge Clk) begin
      if (Reset) begin
         top_q <= PTR_W'(0);
         cnt_q <= CNT_W'(0);
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= {ADDR_W{1'b0}};
         end
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
         if (ras_we_s) begin
            ras_q[ras_widx_s] <= pc_plus_s;
         end
      end
   end

   assign RasEmpty = (cnt_q == CNT_W'(0));
   assign RasFull  = (cnt_q == CNT_FULL);
`else
   assign RasEmpty = 1'b1;
   assign RasFull  = 1'b0;
`endif

   assign PCResult  = pc_q;
   assign PCPlus4   = pc_plus_s;
   assign EPC       = epc_q;
   assign PredTaken = pred_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_pc_fetch_unit;

   localparam int DEPTH = 4;
   localparam logic [31:0] RST_V = 32'h0000_0000;
   localparam logic [31:0] EXC_V = 32'h8000_0180;

   logic        Clk;
   logic        Reset;
   logic        NotStall;
   logic        Redirect;
   logic [31:0] RedirectAddr;
   logic        Exception;
   logic        Call;
   logic        Return;
   logic [31:0] PCResult;
   logic [31:0] PCPlus4;
   logic [31:0] EPC;
   logic        PredTaken;
   logic        RasEmpty;
   logic        RasFull;

   int n_compared;
   int n_mismatched;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic        m_pred;
   logic [31:0] m_ras[$];
   bit          ras_en;

   pc_fetch_unit dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .NotStall    (NotStall),
      .Redirect    (Redirect),
      .RedirectAddr(RedirectAddr),
      .Exception   (Exception),
      .Call        (Call),
      .Return      (Return),
      .PCResult    (PCResult),
      .PCPlus4     (PCPlus4),
      .EPC         (EPC),
      .PredTaken   (PredTaken),
      .RasEmpty    (RasEmpty),
      .RasFull     (RasFull)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Next-state of the architectural view, written from the priority rules
   task automatic model_step(input bit r, input bit ns, input bit rd, input logic [31:0] ra,
                             input bit ex, input bit ca, input bit re);
      logic [31:0] nxt;
      logic [31:0] top;
      nxt = m_pc + 32'd4;
      if (r) begin
         m_pc = RST_V; m_epc = 32'd0; m_pred = 1'b0; m_ras.delete();
      end else if (ex) begin
         m_epc = m_pc; m_pc = EXC_V; m_pred = 1'b0; m_ras.delete();
      end else if (rd) begin
         m_pc = {ra[31:2], 2'b00}; m_pred = 1'b0;
      end else if (!ns) begin
         m_pc = m_pc;
      end else if (ras_en && re && m_ras.size() > 0) begin
         top = m_ras[$];
         if (ca) m_ras[m_ras.size()-1] = nxt;
         else void'(m_ras.pop_back());
         m_pc = top; m_pred = 1'b1;
      end else begin
         if (ras_en && ca) begin
            m_ras.push_back(nxt);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
         m_pc = nxt; m_pred = 1'b0;
      end
   endtask

   task automatic compare_all();
      check_eq("pc",      PCResult, m_pc);
      check_eq("pcplus4", PCPlus4,  m_pc + 32'd4);
      check_eq("epc",     EPC,      m_epc);
      check_eq("pred",    {31'd0, PredTaken}, {31'd0, m_pred});
      check_eq("empty",   {31'd0, RasEmpty},  {31'd0, (m_ras.size() == 0)});
      check_eq("full",    {31'd0, RasFull},   {31'd0, (m_ras.size() == DEPTH)});
   endtask

   task automatic cyc(input bit r, input bit ns, input bit rd, input logic [31:0] ra,
                      input bit ex, input bit ca, input bit re);
      Reset = r; NotStall = ns; Redirect = rd; RedirectAddr = ra;
      Exception = ex; Call = ca; Return = re;
      model_step(r, ns, rd, ra, ex, ca, re);
      @(posedge Clk);
      #1;
      compare_all();
   endtask

   initial begin
      bit r, ns, rd, ex, ca, re;
      logic [31:0] ra;
`ifdef PC_FETCH_RAS_EN
      ras_en = 1'b1;
`else
      ras_en = 1'b0;
`endif
      n_compared = 0; n_mismatched = 0;
      m_pc = 32'd0; m_epc = 32'd0; m_pred = 1'b0;
      Reset = 1'b1; NotStall = 1'b0; Redirect = 1'b0; RedirectAddr = 32'd0;
      Exception = 1'b0; Call = 1'b0; Return = 1'b0;

      // reset then three sequential steps
      cyc(1, 0, 0, 32'd0, 0, 0, 0);
      cyc(1, 0, 0, 32'd0, 0, 0, 0);
      check_eq("rst_pc", PCResult, 32'h0);
      check_eq("rst_empty", {31'd0, RasEmpty}, 32'd1);
      cyc(0, 1, 0, 32'd0, 0, 0, 0);
      cyc(0, 1, 0, 32'd0, 0, 0, 0);
      cyc(0, 1, 0, 32'd0, 0, 0, 0);
      check_eq("seq_pc", PCResult, 32'hC);
      cyc(1, 1, 0, 32'd0, 0, 0, 0);
      check_eq("midrst_pc", PCResult, 32'h0);

      // redirect under stall, then hold
      cyc(0, 1, 1, 32'h10, 0, 0, 0);
      cyc(0, 0, 1, 32'h103, 0, 0, 0);
      check_eq("redir_align", PCResult, 32'h100);
      cyc(0, 0, 0, 32'd0, 0, 1, 1);
      check_eq("stall_hold", PCResult, 32'h100);

      // call / return
      cyc(0, 1, 1, 32'h20, 0, 0, 0);
      cyc(0, 1, 0, 32'd0, 0, 1, 0);
      cyc(0, 1, 1, 32'h40, 0, 0, 0);
      cyc(0, 1, 0, 32'd0, 0, 0, 1);
`ifdef PC_FETCH_RAS_EN
      check_eq("ret_pc", PCResult, 32'h24);
      check_eq("ret_pred", {31'd0, PredTaken}, 32'd1);
`else
      check_eq("ret_pc", PCResult, 32'h44);
`endif
      cyc(0, 1, 0, 32'd0, 0, 0, 1);
      cyc(0, 1, 0, 32'd0, 0, 0, 1);

      // overflow: five calls then four returns
      cyc(1, 0, 0, 32'd0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'd0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'd0, 0, 0, 1);
`ifdef PC_FETCH_RAS_EN
      check_eq("ovf_last", PCResult, 32'h8);
`endif

      // exception beats redirect and call
      cyc(0, 1, 0, 32'd0, 0, 1, 0);
      cyc(0, 1, 1, 32'h50, 0, 0, 0);
      cyc(0, 1, 1, 32'h200, 1, 1, 0);
      check_eq("exc_pc", PCResult, EXC_V);
      check_eq("exc_epc", EPC, 32'h50);

      // call then return from reset
      cyc(1, 0, 0, 32'd0, 0, 0, 0);
      cyc(0, 1, 0, 32'd0, 0, 1, 0);
      cyc(0, 1, 0, 32'd0, 0, 0, 1);
`ifndef PC_FETCH_RAS_EN
      check_eq("noras_pc", PCResult, 32'h8);
`endif

      // address wrap
      cyc(0, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
      cyc(0, 1, 0, 32'd0, 0, 0, 0);
      check_eq("wrap_pc", PCResult, 32'h0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         r  = ($urandom_range(0, 63) == 0);
         ex = ($urandom_range(0, 15) == 0);
         rd = ($urandom_range(0, 9) == 0);
         ns = ($urandom_range(0, 3) != 0);
         ca = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 2) == 0);
         ra = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023);
         cyc(r, ns, rd, ra, ex, ca, re);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
